seq_mult: RTL and testbench

- Iterative, parametrised integer multiplier producing the full 2*WIDTH-bit product.
- Successor to the single-cycle truncating combinational multiplier primitive: adds per-operation signed/unsigned mode, valid/ready handshakes, and a tunable area/latency trade-off (BITS_PER_CYCLE).
- Sits alongside the combinational primitives as a sequential library cell for Filament designs where a full-width combinational multiplier is too large.

---
 rtl/seq_mult_pkg.sv | 21 ++
 rtl/seq_mult_step.sv | 28 ++
 rtl/seq_mult.sv | 128 ++++++++++++
 tb/tb_seq_mult.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the iterative multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter width: $clog2(n), but never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/seq_mult_step.sv
// One radix-2^BITS_PER_CYCLE partial-product step: adds mcand*digit,
// shifted to the digit's position, into the running accumulator.
module seq_mult_step
  import seq_mult_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int POS_W          = 1
) (
  input  logic [2*WIDTH-1:0]        acc,
  input  logic [WIDTH-1:0]          mcand,
  input  logic [BITS_PER_CYCLE-1:0] digit,
  input  logic [POS_W-1:0]          pos,
  output logic [2*WIDTH-1:0]        acc_next
);

  logic [2*WIDTH-1:0] wide_mcand_s;
  logic [2*WIDTH-1:0] wide_digit_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [31:0]        shamt_s;

  assign wide_mcand_s = {{WIDTH{1'b0}}, mcand};
  assign wide_digit_s = {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, digit};
  assign prod_s       = wide_mcand_s * wide_digit_s;
  assign shamt_s      = 32'(pos) * 32'(BITS_PER_CYCLE);
  assign acc_next     = acc + (prod_s << shamt_s);

endmodule

// File: rtl/seq_mult.sv
// Iterative full-width multiplier with valid/ready handshakes; operates on
// operand magnitudes and applies the sign to the final 2*WIDTH-bit product.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     left,
  input  logic [WIDTH-1:0]     right,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
    $error("seq_mult: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
  end

  state_t             state_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [2*WIDTH-1:0] out_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [WIDTH-1:0]   left_mag_s;
  logic [WIDTH-1:0]   right_mag_s;
  logic [CW-1:0]      cnt_r;
  logic [CW-1:0]      pos_s;
  logic               neg_r;
  logic               in_ready_r;
  logic               out_valid_r;

  // Operand magnitudes; -2^(WIDTH-1) maps to the unsigned value 2^(WIDTH-1).
  always_comb begin
    left_mag_s  = left;
    right_mag_s = right;
    if (is_signed && left[WIDTH-1]) begin
      left_mag_s = -left;
    end else begin
      left_mag_s = left;
    end
    if (is_signed && right[WIDTH-1]) begin
      right_mag_s = -right;
    end else begin
      right_mag_s = right;
    end
  end

  assign pos_s = LAST - cnt_r;

  seq_mult_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .POS_W          (CW)
  ) u_step (
    .acc      (acc_r),
    .mcand    (mcand_r),
    .digit    (mplier_r[BITS_PER_CYCLE-1:0]),
    .pos      (pos_s),
    .acc_next (acc_next_s)
  );

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      out_r       <= '0;
      mcand_r     <= '0;
      mplier_r    <= '0;
      cnt_r       <= '0;
      neg_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            mcand_r    <= left_mag_s;
            mplier_r   <= right_mag_s;
            neg_r      <= is_signed & (left[WIDTH-1] ^ right[WIDTH-1]);
            acc_r      <= '0;
            cnt_r      <= LAST;
            in_ready_r <= 1'b0;
            state_r    <= BUSY;
          end
        end
        BUSY: begin
          acc_r    <= acc_next_s;
          mplier_r <= mplier_r >> BITS_PER_CYCLE;
          cnt_r    <= cnt_r - CW'(1);
          if (cnt_r == '0) begin
            out_r       <= neg_r ? -acc_next_s : acc_next_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out       = out_r;

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult: WIDTH=8 with BITS_PER_CYCLE=2 (N=4), plus an
// N=1 instance for the single-step configuration.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  left = 8'd0;
  logic [7:0]  right = 8'd0;
  logic        is_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [7:0]  left2 = 8'd0;
  logic [7:0]  right2 = 8'd0;
  logic        is_signed2 = 1'b0;
  logic        out_valid2;
  logic        out_ready2 = 1'b0;
  logic [15:0] out2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .left      (left),
    .right     (right),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  seq_mult #(.WIDTH(8), .BITS_PER_CYCLE(8)) dut_n1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .left      (left2),
    .right     (right2),
    .is_signed (is_signed2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out       (out2)
  );

  task automatic start_op(input logic [7:0] l, input logic [7:0] r, input logic s);
    left = l; right = r; is_signed = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until out_valid is seen (bounded at 20).
  task automatic wait_done(output int cyc, output bit rdy_seen);
    cyc = 0;
    rdy_seen = (in_ready !== 1'b0);
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
    end
  endtask

  task automatic retire;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out !== 16'h0000) begin n_err++; $display("FAIL reset_out: got %h expected 0000", out); end
    n_cmp++; if (in_ready2 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_n1: got %b expected 1", in_ready2); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    int cyc; bit rdy;
    start_op(8'd200, 8'd250, 1'b0);
    wait_done(cyc, rdy);
    n_cmp++; if (cyc != 4) begin n_err++; $display("FAIL unsigned_latency: got %0d expected 4", cyc); end
    n_cmp++; if (rdy) begin n_err++; $display("FAIL unsigned_in_ready_busy: got 1 expected 0"); end
    n_cmp++; if (out !== 16'hC350) begin n_err++; $display("FAIL unsigned_out: got %h expected c350", out); end
    retire();
  endtask

  task automatic test_signed;
    logic [7:0]  a [4];
    logic [7:0]  b [4];
    logic        s [4];
    logic [15:0] e [4];
    int cyc; bit rdy;
    a = '{8'h80, 8'h80, 8'hFF, 8'hFF};
    b = '{8'h80, 8'h7F, 8'hFF, 8'hFF};
    s = '{1'b1, 1'b1, 1'b1, 1'b0};
    e = '{16'h4000, 16'hC080, 16'h0001, 16'hFE01};
    for (int i = 0; i < 4; i++) begin
      start_op(a[i], b[i], s[i]);
      wait_done(cyc, rdy);
      n_cmp++; if (cyc != 4) begin n_err++; $display("FAIL signed_latency[%0d]: got %0d expected 4", i, cyc); end
      n_cmp++; if (out !== e[i]) begin n_err++; $display("FAIL signed_out[%0d]: got %h expected %h", i, out, e[i]); end
      retire();
    end
  endtask

  task automatic test_backpressure;
    int cyc; bit rdy;
    start_op(8'd3, 8'd5, 1'b0);
    wait_done(cyc, rdy);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin left = 8'd7; right = 8'd7; is_signed = 1'b0; in_valid = 1'b1; end
      @(posedge clk); #1;
      n_cmp++; if (out !== 16'h000F) begin n_err++; $display("FAIL bp_out_hold[%0d]: got %h expected 000f", i, out); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
    end
    in_valid = 1'b0;
    retire();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_after_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out !== 16'h000F) begin n_err++; $display("FAIL bp_after_out: got %h expected 000f", out); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_after_ready: got %b expected 1", in_ready); end
    start_op(8'd6, 8'd7, 1'b0);
    wait_done(cyc, rdy);
    n_cmp++; if (out !== 16'h002A) begin n_err++; $display("FAIL bp_next_out: got %h expected 002a", out); end
    retire();
  endtask

  task automatic test_reset_abort;
    int cyc; bit rdy;
    start_op(8'd100, 8'd100, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out !== 16'h0000) begin n_err++; $display("FAIL abort_out: got %h expected 0000", out); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    start_op(8'd3, 8'd5, 1'b0);
    wait_done(cyc, rdy);
    n_cmp++; if (cyc != 4) begin n_err++; $display("FAIL abort_next_latency: got %0d expected 4", cyc); end
    n_cmp++; if (out !== 16'h000F) begin n_err++; $display("FAIL abort_next_out: got %h expected 000f", out); end
    retire();
  endtask

  task automatic test_back_to_back;
    logic [7:0]  a [6];
    logic [7:0]  b [6];
    logic        s [6];
    logic [15:0] e [6];
    int acc_at [6];
    int idx, got, cyc;
    bit take;
    a = '{8'd13,  8'hF6, 8'd255, 8'h9C, 8'd127, 8'd170};
    b = '{8'd11,  8'd12, 8'd2,   8'h9C, 8'h81,  8'd85};
    s = '{1'b0,   1'b1,  1'b0,   1'b1,  1'b1,   1'b0};
    e = '{16'h008F, 16'hFF88, 16'h01FE, 16'h2710, 16'hC0FF, 16'h3872};
    idx = 0; got = 0; cyc = 0;
    left = a[0]; right = b[0]; is_signed = s[0];
    in_valid = 1'b1; out_ready = 1'b1;
    while (got < 6 && cyc < 100) begin
      take = (in_ready === 1'b1) && (idx < 6);
      @(posedge clk); #1;
      cyc++;
      if (take) begin
        acc_at[idx] = cyc;
        idx++;
        if (idx < 6) begin left = a[idx]; right = b[idx]; is_signed = s[idx]; end
        else in_valid = 1'b0;
      end
      if (out_valid === 1'b1) begin
        n_cmp++; if (out !== e[got]) begin n_err++; $display("FAIL stream_out[%0d]: got %h expected %h", got, out, e[got]); end
        n_cmp++; if (cyc - acc_at[got] != 4) begin n_err++; $display("FAIL stream_latency[%0d]: got %0d expected 4", got, cyc - acc_at[got]); end
        got++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (got != 6) begin n_err++; $display("FAIL stream_count: got %0d expected 6", got); end
  endtask

  task automatic test_zero_and_n1;
    int cyc; bit rdy;
    start_op(8'd0, 8'd255, 1'b0);
    wait_done(cyc, rdy);
    n_cmp++; if (cyc != 4) begin n_err++; $display("FAIL zero_latency: got %0d expected 4", cyc); end
    n_cmp++; if (out !== 16'h0000) begin n_err++; $display("FAIL zero_out: got %h expected 0000", out); end
    retire();
    left2 = 8'h80; right2 = 8'h80; is_signed2 = 1'b1; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    cyc = 0;
    n_cmp++; if (out_valid2 !== 1'b0) begin n_err++; $display("FAIL n1_busy_valid: got %b expected 0", out_valid2); end
    while (out_valid2 !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++; if (cyc != 1) begin n_err++; $display("FAIL n1_latency: got %0d expected 1", cyc); end
    n_cmp++; if (out2 !== 16'h4000) begin n_err++; $display("FAIL n1_out: got %h expected 4000", out2); end
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    n_cmp++; if (in_ready2 !== 1'b1) begin n_err++; $display("FAIL n1_return_idle: got %b expected 1", in_ready2); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_zero_and_n1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
